// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32 instruction fields into 32-bit words. It rejects
// immediates that the target format cannot represent, and queues legal words
// in a small FIFO. Each queued word is tagged with a sequential
// instruction-memory address.
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err_valid,
  output logic [6:0]  err_opcode,
  output logic [15:0] err_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // FIFO storage and bookkeeping
  logic [31:0]      r_mem_instr [DEPTH];
  logic [31:0]      r_mem_addr  [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_addr;

  // Error reporting state
  logic             r_err_valid;
  logic [6:0]       r_err_opcode;
  logic [15:0]      r_err_count;

  // Encoder results and handshake qualifiers
  logic [31:0]      w_instr;
  logic             w_legal;
  logic             w_imm_fits12;
  logic             w_imm_fits13;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_illegal;

  // A 12-bit signed field holds the value only if bits 31..11 are pure sign.
  assign w_imm_fits12 = (in_imm[31:11] == '0) || (&in_imm[31:11]);
  // A 13-bit branch offset holds the value only if bits 31..12 are pure sign.
  assign w_imm_fits13 = (in_imm[31:12] == '0) || (&in_imm[31:12]);

  // Pack fields for the requested format and judge whether the immediate fits
  always_comb begin
    // NOTE: every combinational output gets a default first. Then no path
    // through the case leaves it unassigned, and no latch is inferred.
    w_instr = '0;
    w_legal = 1'b0;
    case (in_opcode)
      OP_IMM, OP_JALR, OP_LOAD: begin
        w_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        w_legal = w_imm_fits12;
      end
      OP_LUI: begin
        w_instr = {in_imm[31:12], in_rd, in_opcode};
        w_legal = (in_imm[11:0] == '0);
      end
      OP_BRANCH: begin
        w_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                   in_imm[4:1], in_imm[11], in_opcode};
        w_legal = !in_imm[0] && w_imm_fits13;
      end
      OP_STORE: begin
        w_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        w_legal = w_imm_fits12;
      end
      OP_REG: begin
        w_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        w_legal = 1'b1;
      end
      default: begin
        w_instr = '0;
        w_legal = 1'b0;
      end
    endcase
  end

  // A flush blocks acceptance, so a request presented alongside it is ignored.
  assign in_ready  = (r_count < FULL_CNT) && !flush;
  assign w_accept  = in_valid && in_ready;
  assign w_push    = w_accept && w_legal;
  assign w_illegal = w_accept && !w_legal;
  assign w_pop     = (r_count != '0) && out_ready && !flush;

  // Pointer, occupancy and address-counter update; flush outranks push/pop
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments. Every register
    // then samples pre-edge values, whatever the statement order.
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_addr   <= BASE_ADDR;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_addr   <= BASE_ADDR;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_addr   <= r_addr + 32'd4;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Write the encoded word and its address tag into the tail slot
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset. Outputs are masked
    // while the FIFO is empty, so stale contents are never observed.
    if (w_push) begin
      r_mem_instr[r_wr_ptr] <= w_instr;
      r_mem_addr[r_wr_ptr]  <= r_addr;
    end
  end

  // Pulse on an illegal acceptance, latch its opcode, count with saturation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_valid  <= 1'b0;
      r_err_opcode <= '0;
      r_err_count  <= '0;
    end else begin
      r_err_valid <= w_illegal;
      if (w_illegal) begin
        r_err_opcode <= in_opcode;
        if (r_err_count != 16'hFFFF) begin
          r_err_count <= r_err_count + 16'd1;
        end
      end
    end
  end

  // Head outputs come only from registered state, zeroed while empty.
  assign out_valid  = (r_count != '0);
  assign out_instr  = out_valid ? r_mem_instr[r_rd_ptr] : '0;
  assign out_addr   = out_valid ? r_mem_addr[r_rd_ptr]  : '0;
  assign err_valid  = r_err_valid;
  assign err_opcode = r_err_opcode;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder. Expected words and addresses are
// queued when a request is accepted, and compared when the head is popped.
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'h0000_0000;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err_valid;
  logic [6:0]  err_opcode;
  logic [15:0] err_count;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } sb_entry_t;

  sb_entry_t   sb_q[$];
  logic [31:0] exp_addr;
  bit          exp_err_pend;
  int          n_checks;
  int          n_errors;
  int          n_pops;
  int          n_err_pulses;

  instr_encoder #(.DEPTH(4), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_addr   (out_addr),
    .err_valid  (err_valid),
    .err_opcode (err_opcode),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference encoder: returns {legal, word}.
  function automatic logic [32:0] model_encode(input logic [6:0] op, input logic [4:0] rd,
                                               input logic [4:0] rs1, input logic [4:0] rs2,
                                               input logic [2:0] f3, input logic [6:0] f7,
                                               input logic [31:0] imm);
    logic [31:0] w;
    logic        ok;
    logic        s12;
    logic        s13;
    s12 = (imm[31:11] == 21'h0) || (imm[31:11] == 21'h1F_FFFF);
    s13 = (imm[31:12] == 20'h0) || (imm[31:12] == 20'hF_FFFF);
    w   = 32'h0;
    ok  = 1'b0;
    if (op == OP_IMM || op == OP_JALR || op == OP_LOAD) begin
      w  = {imm[11:0], rs1, f3, rd, op};
      ok = s12;
    end else if (op == OP_LUI) begin
      w  = {imm[31:12], rd, op};
      ok = (imm[11:0] == 12'h0);
    end else if (op == OP_BRANCH) begin
      w  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      ok = (imm[0] == 1'b0) && s13;
    end else if (op == OP_STORE) begin
      w  = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      ok = s12;
    end else if (op == OP_REG) begin
      w  = {f7, rs2, rs1, f3, rd, op};
      ok = 1'b1;
    end
    return {ok, w};
  endfunction

  // Present one request, wait (bounded) for acceptance, then record expectations.
  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm);
    logic [32:0] m;
    bit          done;
    int          waited;
    m = model_encode(op, rd, rs1, rs2, f3, f7, imm);
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    in_valid  = 1'b1;
    done = 1'b0;
    waited = 0;
    while (!done && waited <= 50) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      else waited++;
    end
    if (!done) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    if (done) begin
      if (m[32]) begin
        sb_q.push_back({m[31:0], exp_addr});
        exp_addr = exp_addr + 32'd4;
      end else begin
        exp_err_pend = 1'b1;
      end
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic clear_model();
    sb_q.delete();
    exp_addr     = BASE;
    exp_err_pend = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_model();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_drain();
    int cyc;
    cyc = 0;
    out_ready = 1'b1;
    while (out_valid && cyc < 50) begin
      @(posedge clk);
      #1 cyc++;
    end
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check("drain_sb_left", 32'(sb_q.size()), 32'd0);
  endtask

  // Output monitor: error pulse against expectation, head word against scoreboard.
  always @(negedge clk) begin
    sb_entry_t e;
    if (!reset) begin
      check("err_valid", 32'(err_valid), 32'(exp_err_pend));
      if (err_valid) n_err_pulses++;
      exp_err_pend = 1'b0;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("pop_with_empty_scoreboard", 32'(out_valid), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("out_instr", out_instr, e.instr);
          check("out_addr", out_addr, e.addr);
          n_pops++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   pulses0;
    int   pops0;
    time  t0;
    n_checks = 0; n_errors = 0; n_pops = 0; n_err_pulses = 0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    clear_model();

    // Reset values
    #2;
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_out_instr",  out_instr,       32'd0);
    check("rst_out_addr",   out_addr,        32'd0);
    check("rst_err_valid",  32'(err_valid),  32'd0);
    check("rst_err_opcode", 32'(err_opcode), 32'd0);
    check("rst_err_count",  32'(err_count),  32'd0);
    check("rst_in_ready",   32'(in_ready),   32'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // I-type round trip, head visible one cycle after acceptance
    send(OP_IMM, 5'd5, 5'd6, 5'd0, 3'b000, 7'd0, 32'hFFFF_F800);
    check("itype_valid", 32'(out_valid), 32'd1);
    check("itype_word",  out_instr, 32'h8003_0293);
    check("itype_addr",  out_addr,  32'h0);
    check("itype_decode", {{20{out_instr[31]}}, out_instr[31:20]}, 32'hFFFF_F800);
    wait_drain();

    // Branch and store encodings at addresses 0 and 4
    do_reset();
    out_ready = 1'b0;
    send(OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'b001, 7'd0, 32'h0000_0FFE);
    check("branch_word", out_instr, 32'h7E20_9FE3);
    check("branch_addr", out_addr,  32'h0);
    send(OP_STORE, 5'd0, 5'd2, 5'd8, 3'b010, 7'd0, 32'hFFFF_FFFC);
    check("branch_hold", out_instr, 32'h7E20_9FE3);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("store_word", out_instr, 32'hFE81_2E23);
    check("store_addr", out_addr,  32'h4);
    wait_drain();

    // Illegal immediates and opcode
    do_reset();
    out_ready = 1'b0;
    pulses0 = n_err_pulses;
    send(OP_IMM,    5'd1, 5'd1, 5'd0, 3'b000, 7'd0, 32'h0000_0800);
    send(OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'h0000_0003);
    send(OP_LUI,    5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h0000_1001);
    send(7'h7F,     5'd1, 5'd1, 5'd1, 3'b000, 7'd0, 32'h0000_0000);
    @(negedge clk);
    @(posedge clk);
    #1;
    check("illegal_pulses",  32'(n_err_pulses - pulses0), 32'd4);
    check("illegal_count",   32'(err_count),  32'd4);
    check("illegal_opcode",  32'(err_opcode), 32'h7F);
    check("illegal_no_push", 32'(out_valid),  32'd0);
    send(OP_LUI, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h1234_5000);
    check("legal_after_err_word", out_instr, 32'h1234_50B7);
    check("legal_after_err_addr", out_addr,  32'h0);
    wait_drain();

    // Backpressure: four fill the FIFO, the fifth stalls without drop or error
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(OP_IMM, 5'(i + 1), 5'(i + 2), 5'd0, 3'b000, 7'd0, 32'(i * 7 - 5));
    end
    check("full_in_ready", 32'(in_ready), 32'd0);
    in_opcode = OP_REG; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(OP_REG,   5'd9,  5'd10, 5'd11, 3'b111, 7'h20, 32'hDEAD_BEEF);
    send(OP_STORE, 5'd0,  5'd3,  5'd4,  3'b001, 7'd0,  32'h0000_07FF);
    wait_drain();
    check("bp_err_count", 32'(err_count), 32'd0);

    // Continuous stream: one word per cycle, pointers wrap
    do_reset();
    out_ready = 1'b1;
    pops0 = n_pops;
    t0 = $time;
    for (int i = 0; i < 10; i++) begin
      send(OP_REG, 5'(i), 5'(i + 3), 5'(31 - i), 3'(i), 7'(i * 5), 32'h0);
    end
    check("stream_cycles", 32'(($time - t0) / 10), 32'd10);
    wait_drain();
    check("stream_pops", 32'(n_pops - pops0), 32'd10);
    check("stream_next_addr", exp_addr, 32'd40);

    // Flush with three words queued
    do_reset();
    out_ready = 1'b0;
    send(7'h7F, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      send(OP_LOAD, 5'(i), 5'd2, 5'd0, 3'b010, 7'd0, 32'(i * 4));
    end
    flush = 1'b1;
    in_opcode = OP_IMM; in_imm = 32'h1; in_valid = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    in_valid = 1'b0;
    sb_q.delete();
    exp_addr = BASE;
    check("flush_out_valid", 32'(out_valid),  32'd0);
    check("flush_err_count", 32'(err_count),  32'd1);
    check("flush_err_op",    32'(err_opcode), 32'h7F);
    out_ready = 1'b1;
    send(OP_IMM, 5'd3, 5'd4, 5'd0, 3'b100, 7'd0, 32'h0000_0123);
    check("flush_next_addr", out_addr, BASE);
    wait_drain();

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(OP_IMM, 5'd1, 5'd1, 5'd0, 3'b000, 7'd0, 32'(i));
    end
    send(7'h7E, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'h0);
    #1 reset = 1'b1;
    clear_model();
    #1;
    check("arst_out_valid",  32'(out_valid),  32'd0);
    check("arst_out_instr",  out_instr,       32'd0);
    check("arst_out_addr",   out_addr,        32'd0);
    check("arst_err_valid",  32'(err_valid),  32'd0);
    check("arst_err_opcode", 32'(err_opcode), 32'd0);
    check("arst_err_count",  32'(err_count),  32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    send(OP_LUI, 5'd2, 5'd0, 5'd0, 3'b000, 7'd0, 32'hABCD_E000);
    check("arst_next_addr", out_addr, BASE);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
